// File: rtl/ariane_core_wake_ctrl.sv
// Purpose: sequences Ariane core reset release behind SRAM init + L1.5 wake, re-runs release on ndmreset.
// Latency: all outputs registered; gated interrupt/debug lines follow inputs by one cycle while running.
// Backpressure: none; wake pulses are latched so an early wake is never lost.
//
// Ports:
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   wake_int_i                     one-cycle L1.5 wake-up interrupt pulse
//   ndmreset_req_i                 debug-module core reset request (level, acted on only in RUN)
//   irq_i, ipi_i, time_irq_i,
//   debug_req_i                    synchronized interrupt/debug lines from the tile
//   core_rst_no                    active-low core reset (0 = core held)
//   irq_o, ipi_o, time_irq_o,
//   debug_req_o                    gated copies, forced 0 unless the core is running
//   running_o, state_o             observability: RUN flag and encoded FSM state
module ariane_core_wake_ctrl #(
    parameter int unsigned InitCycles   = 32768,
    parameter bit          WaitForWake  = 1'b1,
    parameter int unsigned ReleaseDelay = 4,
    parameter int unsigned HoldCycles   = 16,
    parameter int unsigned CntWidth     = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       wake_int_i,
    input  logic       ndmreset_req_i,
    input  logic [1:0] irq_i,
    input  logic       ipi_i,
    input  logic       time_irq_i,
    input  logic       debug_req_i,
    output logic       core_rst_no,
    output logic [1:0] irq_o,
    output logic       ipi_o,
    output logic       time_irq_o,
    output logic       debug_req_o,
    output logic       running_o,
    output logic [2:0] state_o
);

    localparam logic [2:0] ST_SRAM_INIT = 3'd0;
    localparam logic [2:0] ST_WAIT_WAKE = 3'd1;
    localparam logic [2:0] ST_RELEASE   = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;

    // Terminal counts. InitCycles==0 behaves like a single pass-through cycle.
    localparam logic [CntWidth-1:0] InitLast =
        (InitCycles == 0) ? '0 : CntWidth'(InitCycles - 1);
    localparam logic [CntWidth-1:0] RelLast  = CntWidth'(ReleaseDelay - 1);
    localparam logic [CntWidth-1:0] HoldLast = CntWidth'(HoldCycles - 1);

    logic [2:0]          state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                wake_seen_q, wake_seen_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic                running_q, running_d;
    logic [1:0]          irq_q, irq_d;
    logic                ipi_q, ipi_d;
    logic                time_irq_q, time_irq_d;
    logic                debug_req_q, debug_req_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        // Sticky until reset, so a wake arriving during SRAM init or on an exit edge is kept.
        wake_seen_d = wake_seen_q | wake_int_i;

        case (state_q)
            ST_SRAM_INIT: begin
                if (cnt_q == InitLast) begin
                    state_d = ST_WAIT_WAKE;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_WAKE: begin
                cnt_d = '0;
                if (wake_seen_q || wake_int_i || !WaitForWake) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == RelLast) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (ndmreset_req_i) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Debug reset skips SRAM init and the wake gate entirely.
                if (cnt_q == HoldLast) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_SRAM_INIT;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered views of the next state, so they change on the transition edge.
        core_rst_n_d = (state_d == ST_RUN);
        running_d    = (state_d == ST_RUN);

        // Pass-through only while staying in RUN; the RUN entry edge and the ndmreset edge load 0.
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            irq_d       = irq_i;
            ipi_d       = ipi_i;
            time_irq_d  = time_irq_i;
            debug_req_d = debug_req_i;
        end else begin
            irq_d       = '0;
            ipi_d       = 1'b0;
            time_irq_d  = 1'b0;
            debug_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_SRAM_INIT;
            cnt_q        <= '0;
            wake_seen_q  <= 1'b0;
            core_rst_n_q <= 1'b0;
            running_q    <= 1'b0;
            irq_q        <= '0;
            ipi_q        <= 1'b0;
            time_irq_q   <= 1'b0;
            debug_req_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wake_seen_q  <= wake_seen_d;
            core_rst_n_q <= core_rst_n_d;
            running_q    <= running_d;
            irq_q        <= irq_d;
            ipi_q        <= ipi_d;
            time_irq_q   <= time_irq_d;
            debug_req_q  <= debug_req_d;
        end
    end

    assign core_rst_no = core_rst_n_q;
    assign running_o   = running_q;
    assign irq_o       = irq_q;
    assign ipi_o       = ipi_q;
    assign time_irq_o  = time_irq_q;
    assign debug_req_o = debug_req_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_ariane_core_wake_ctrl.sv
// Purpose: directed bench for ariane_core_wake_ctrl with two parameter sets (full sequence, and pass-through).
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: none; every loop has a fixed edge count so the run always ends.
module tb_ariane_core_wake_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: InitCycles=8, WaitForWake=1, ReleaseDelay=4, HoldCycles=16
    logic       rst_a = 1'b0, wake_a = 1'b0, ndm_a = 1'b0;
    logic [1:0] irq_a = 2'b00;
    logic       ipi_a = 1'b0, tim_a = 1'b0, dbg_a = 1'b0;
    logic       core_rst_a, ipi_o_a, tim_o_a, dbg_o_a, run_a;
    logic [1:0] irq_o_a;
    logic [2:0] state_a;

    // Instance B: InitCycles=0, WaitForWake=0, ReleaseDelay=1
    logic       rst_b = 1'b0, wake_b = 1'b0, ndm_b = 1'b0;
    logic [1:0] irq_b = 2'b00;
    logic       ipi_b = 1'b0, tim_b = 1'b0, dbg_b = 1'b0;
    logic       core_rst_b, ipi_o_b, tim_o_b, dbg_o_b, run_b;
    logic [1:0] irq_o_b;
    logic [2:0] state_b;

    ariane_core_wake_ctrl #(
        .InitCycles(8), .WaitForWake(1'b1), .ReleaseDelay(4), .HoldCycles(16), .CntWidth(16)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_a), .wake_int_i(wake_a), .ndmreset_req_i(ndm_a),
        .irq_i(irq_a), .ipi_i(ipi_a), .time_irq_i(tim_a), .debug_req_i(dbg_a),
        .core_rst_no(core_rst_a), .irq_o(irq_o_a), .ipi_o(ipi_o_a), .time_irq_o(tim_o_a),
        .debug_req_o(dbg_o_a), .running_o(run_a), .state_o(state_a)
    );

    ariane_core_wake_ctrl #(
        .InitCycles(0), .WaitForWake(1'b0), .ReleaseDelay(1), .HoldCycles(16), .CntWidth(16)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_b), .wake_int_i(wake_b), .ndmreset_req_i(ndm_b),
        .irq_i(irq_b), .ipi_i(ipi_b), .time_irq_i(tim_b), .debug_req_i(dbg_b),
        .core_rst_no(core_rst_b), .irq_o(irq_o_b), .ipi_o(ipi_o_b), .time_irq_o(tim_o_b),
        .debug_req_o(dbg_o_b), .running_o(run_b), .state_o(state_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected state during a fresh bring-up of instance A (edge e after reset release).
    function automatic logic [2:0] bringup_state(input int e);
        if (e < 8)  return 3'd0;
        if (e == 8) return 3'd1;
        if (e < 13) return 3'd2;
        return 3'd3;
    endfunction

    initial begin
        // Reset state, with interrupt stimulus active to show it is blocked.
        irq_a = 2'b11; ipi_a = 1'b1; tim_a = 1'b1; dbg_a = 1'b1; wake_a = 1'b1;
        tick(); tick();
        chk("rst_state",    32'(state_a),    32'd0);
        chk("rst_core_rst", 32'(core_rst_a), 32'd0);
        chk("rst_running",  32'(run_a),      32'd0);
        chk("rst_irq_o",    32'(irq_o_a),    32'd0);
        chk("rst_ipi_o",    32'(ipi_o_a),    32'd0);
        chk("rst_b_state",  32'(state_b),    32'd0);
        chk("rst_b_core",   32'(core_rst_b), 32'd0);

        // T1 + T6 + T3(pre-RUN gating): wake pulse sampled at edge 2, release at edge 13.
        rst_a = 1'b1; rst_b = 1'b1;
        irq_a = 2'b10; tim_a = 1'b1; ipi_a = 1'b1; dbg_a = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            wake_a = (e == 2);
            tick();
            chk("t1_state",    32'(state_a),    32'(bringup_state(e)));
            chk("t1_core_rst", 32'(core_rst_a), 32'(e >= 13));
            chk("t1_running",  32'(run_a),      32'(e >= 13));
            chk("t1_irq_gate", 32'(irq_o_a),    32'd0);
            chk("t1_tim_gate", 32'(tim_o_a),    32'd0);
            chk("t1_dbg_gate", 32'(dbg_o_a),    32'd0);
            if (e <= 3) begin
                chk("t6_state",    32'(state_b),    32'(e));
                chk("t6_core_rst", 32'(core_rst_b), 32'(e == 3));
            end
        end
        wake_a = 1'b0;

        // T3: gated lines follow inputs with one cycle of latency in RUN.
        irq_a = 2'b10; tim_a = 1'b1; ipi_a = 1'b0; dbg_a = 1'b0;
        tick();
        chk("t3_irq_o", 32'(irq_o_a), 32'h2);
        chk("t3_tim_o", 32'(tim_o_a), 32'd1);
        chk("t3_ipi_o", 32'(ipi_o_a), 32'd0);
        chk("t3_dbg_o", 32'(dbg_o_a), 32'd0);
        irq_a = 2'b01; tim_a = 1'b0; ipi_a = 1'b1; dbg_a = 1'b1;
        tick();
        chk("t3b_irq_o", 32'(irq_o_a), 32'h1);
        chk("t3b_tim_o", 32'(tim_o_a), 32'd0);
        chk("t3b_ipi_o", 32'(ipi_o_a), 32'd1);
        chk("t3b_dbg_o", 32'(dbg_o_a), 32'd1);

        // T4: one-cycle ndmreset pulse -> HOLD 16, RELEASE 4, RUN; SRAM_INIT not revisited.
        irq_a = 2'b11; ndm_a = 1'b1;
        tick();
        ndm_a = 1'b0; irq_a = 2'b00; ipi_a = 1'b0; dbg_a = 1'b0;
        chk("t4_state",    32'(state_a),    32'd4);
        chk("t4_core_rst", 32'(core_rst_a), 32'd0);
        chk("t4_running",  32'(run_a),      32'd0);
        chk("t4_irq_o",    32'(irq_o_a),    32'd0);
        chk("t4_ipi_o",    32'(ipi_o_a),    32'd0);
        for (int k = 2; k <= 21; k++) begin
            tick();
            chk("t4_seq_state", 32'(state_a),    32'((k <= 16) ? 3'd4 : (k <= 20) ? 3'd2 : 3'd3));
            chk("t4_seq_core",  32'(core_rst_a), 32'(k == 21));
        end

        // T5a: reset during RUN clears outputs and wake_seen; T2: wait indefinitely for a new wake.
        irq_a = 2'b11;
        tick();
        chk("t5_pre_irq_o", 32'(irq_o_a), 32'h3);
        rst_a = 1'b0;
        tick();
        chk("t5_state",    32'(state_a),    32'd0);
        chk("t5_core_rst", 32'(core_rst_a), 32'd0);
        chk("t5_running",  32'(run_a),      32'd0);
        chk("t5_irq_o",    32'(irq_o_a),    32'd0);
        rst_a = 1'b1; irq_a = 2'b00;
        for (int e = 1; e <= 1008; e++) begin
            tick();
            if (e == 7) chk("t2_init_state", 32'(state_a), 32'd0);
            if (e >= 8) begin
                chk("t2_wait_state", 32'(state_a),    32'd1);
                chk("t2_wait_core",  32'(core_rst_a), 32'd0);
            end
        end
        wake_a = 1'b1;
        tick();
        wake_a = 1'b0;
        chk("t2_release", 32'(state_a), 32'd2);
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk("t2_rel_state", 32'(state_a),    32'((j == 4) ? 3'd3 : 3'd2));
            chk("t2_rel_core",  32'(core_rst_a), 32'(j == 4));
        end

        // T5b: reset during RELEASE (reset beats a simultaneous wake), then a wake on the SRAM_INIT exit edge.
        ndm_a = 1'b1;
        tick();
        ndm_a = 1'b0;
        chk("t5b_hold", 32'(state_a), 32'd4);
        repeat (16) tick();
        chk("t5b_release", 32'(state_a), 32'd2);
        tick();
        rst_a = 1'b0; wake_a = 1'b1;
        tick();
        chk("t5b_state",    32'(state_a),    32'd0);
        chk("t5b_core_rst", 32'(core_rst_a), 32'd0);
        chk("t5b_running",  32'(run_a),      32'd0);
        rst_a = 1'b1; wake_a = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            wake_a = (e == 8);
            tick();
            chk("t5c_state",    32'(state_a),    32'(bringup_state(e)));
            chk("t5c_core_rst", 32'(core_rst_a), 32'(e >= 13));
        end
        wake_a = 1'b0;

        // Instance B must still be running undisturbed.
        chk("t6_run_hold", 32'(run_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
